// File: rtl/can_rx_frame_reader.sv
// can_rx_frame_reader: drains an SJA1000-style receive buffer on interrupt
// and streams each frame (info, ID, data bytes) over a valid/ready port.
module can_rx_frame_reader #(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              res_n,
    input  logic              irq_ni,
    output logic              reg_re_o,
    output logic [ADDR_W-1:0] reg_addr_read_o,
    input  logic [7:0]        reg_data_i,
    output logic              reg_we_o,
    output logic [ADDR_W-1:0] reg_addr_write_o,
    output logic [7:0]        reg_data_o,
    output logic              frm_valid_o,
    input  logic              frm_ready_i,
    output logic [7:0]        frm_data_o,
    output logic              frm_first_o,
    output logic              frm_last_o,
    output logic              busy_o,
    output logic [15:0]       frame_cnt_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_IR   = 3'd1;
    localparam logic [2:0] S_RD_INFO = 3'd2;
    localparam logic [2:0] S_EMIT    = 3'd3;
    localparam logic [2:0] S_RD_BYTE = 3'd4;
    localparam logic [2:0] S_WR_RRB  = 3'd5;
    localparam logic [2:0] S_RD_SR   = 3'd6;

    localparam logic [1:0]        LAT     = 2'(RD_LAT);
    localparam logic [ADDR_W-1:0] A_CMR   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_SR    = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_IR    = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_INFO  = ADDR_W'(16);

    logic [2:0]        r_state;
    logic [1:0]        r_wait;
    logic              r_re;
    logic [ADDR_W-1:0] r_raddr;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [7:0]        r_wdata;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_last;
    logic [7:0]        r_byte;
    logic [15:0]       r_cnt;

    logic              w_ff;
    logic              w_rtr;
    logic [3:0]        w_dlc;
    logic [3:0]        w_ndata;
    logic [3:0]        w_nbytes;
    logic [ADDR_W-1:0] w_last_ptr;
    logic              w_rd_done;
    logic              w_emit;

    // Frame length from the info byte currently on the read bus
    always_comb begin
        w_ff       = reg_data_i[7];
        w_rtr      = reg_data_i[6];
        w_dlc      = reg_data_i[3:0];
        w_ndata    = w_rtr ? 4'd0 : ((w_dlc > 4'd8) ? 4'd8 : w_dlc);
        w_nbytes   = 4'd1 + (w_ff ? 4'd4 : 4'd2) + w_ndata;
        w_last_ptr = A_INFO + {{(ADDR_W-4){1'b0}}, w_nbytes} - ADDR_W'(1);
        w_rd_done  = (r_wait == 2'd0);
        w_emit     = (r_state == S_EMIT);
    end

    // Main sequencer: register accesses, stream emission, buffer release
    always_ff @(posedge clk_i or negedge res_n) begin
        if (!res_n) begin
            r_state <= S_IDLE;
            r_wait  <= 2'd0;
            r_re    <= 1'b0;
            r_raddr <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= 8'd0;
            r_ptr   <= '0;
            r_last  <= '0;
            r_byte  <= 8'd0;
            r_cnt   <= 16'd0;
        end else begin
            r_re <= 1'b0;
            r_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!irq_ni) begin
                        r_state <= S_RD_IR;
                        r_re    <= 1'b1;
                        r_raddr <= A_IR;
                        r_wait  <= LAT;
                    end
                end
                S_RD_IR: begin
                    if (!w_rd_done) begin
                        r_wait <= r_wait - 2'd1;
                    end else if (reg_data_i[0]) begin
                        r_state <= S_RD_INFO;
                        r_re    <= 1'b1;
                        r_raddr <= A_INFO;
                        r_wait  <= LAT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RD_INFO: begin
                    if (!w_rd_done) begin
                        r_wait <= r_wait - 2'd1;
                    end else begin
                        r_byte  <= reg_data_i;
                        r_last  <= w_last_ptr;
                        r_ptr   <= A_INFO;
                        r_state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (frm_ready_i) begin
                        if (r_ptr == r_last) begin
                            r_state <= S_WR_RRB;
                            r_we    <= 1'b1;
                            r_waddr <= A_CMR;
                            r_wdata <= 8'h04;
                        end else begin
                            r_state <= S_RD_BYTE;
                            r_ptr   <= r_ptr + ADDR_W'(1);
                            r_re    <= 1'b1;
                            r_raddr <= r_ptr + ADDR_W'(1);
                            r_wait  <= LAT;
                        end
                    end
                end
                S_RD_BYTE: begin
                    if (!w_rd_done) begin
                        r_wait <= r_wait - 2'd1;
                    end else begin
                        r_byte  <= reg_data_i;
                        r_state <= S_EMIT;
                    end
                end
                S_WR_RRB: begin
                    r_cnt   <= r_cnt + 16'd1;
                    r_state <= S_RD_SR;
                    r_re    <= 1'b1;
                    r_raddr <= A_SR;
                    r_wait  <= LAT;
                end
                S_RD_SR: begin
                    if (!w_rd_done) begin
                        r_wait <= r_wait - 2'd1;
                    end else if (reg_data_i[0]) begin
                        r_state <= S_RD_INFO;
                        r_re    <= 1'b1;
                        r_raddr <= A_INFO;
                        r_wait  <= LAT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign reg_re_o         = r_re;
    assign reg_addr_read_o  = r_raddr;
    assign reg_we_o         = r_we;
    assign reg_addr_write_o = r_waddr;
    assign reg_data_o       = r_wdata;
    assign frm_valid_o      = w_emit;
    assign frm_data_o       = r_byte;
    assign frm_first_o      = w_emit && (r_ptr == A_INFO);
    assign frm_last_o       = w_emit && (r_ptr == r_last);
    assign busy_o           = (r_state != S_IDLE);
    assign frame_cnt_o      = r_cnt;

endmodule

// File: tb/tb_can_rx_frame_reader.sv
// tb_can_rx_frame_reader: directed bench with a small controller register
// model, stream capture and hand-computed expectations.
module tb_can_rx_frame_reader;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic        irq_n = 1'b1;
    logic        ready = 1'b1;
    logic [7:0]  rdata = 8'h00;
    logic        re, we, valid, first, last, busy;
    logic [7:0]  raddr, waddr, wdata, fdata;
    logic [15:0] fcnt;

    can_rx_frame_reader #(.RD_LAT(1), .ADDR_W(8)) dut (
        .clk_i(clk), .res_n(res_n), .irq_ni(irq_n),
        .reg_re_o(re), .reg_addr_read_o(raddr), .reg_data_i(rdata),
        .reg_we_o(we), .reg_addr_write_o(waddr), .reg_data_o(wdata),
        .frm_valid_o(valid), .frm_ready_i(ready), .frm_data_o(fdata),
        .frm_first_o(first), .frm_last_o(last),
        .busy_o(busy), .frame_cnt_o(fcnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // controller model state
    logic [7:0] ir_val = 8'h00;
    logic [7:0] buf0 [0:15];
    logic [7:0] buf1 [0:15];
    logic [7:0] sr_seq [0:3];
    int rd_total = 0, sr_total = 0, wr_total = 0, cap_total = 0;
    int rd_base = 0, sr_base = 0, wr_base = 0, cap_base = 0;
    logic [7:0] rd_log [0:1023];
    logic [7:0] wa_log [0:255];
    logic [7:0] wd_log [0:255];
    logic [7:0] st_data [0:1023];
    logic       st_first [0:1023];
    logic       st_last [0:1023];
    logic [7:0] eq [$];

    // register read/write model (1-cycle read latency) and stream capture
    always @(posedge clk) begin
        if (re) begin
            rd_log[rd_total % 1024] <= raddr;
            rd_total <= rd_total + 1;
            if (raddr == 8'd3) begin
                rdata <= ir_val;
            end else if (raddr == 8'd2) begin
                rdata <= (sr_total - sr_base < 4) ?
                         sr_seq[(sr_total - sr_base) % 4] : 8'h00;
                sr_total <= sr_total + 1;
            end else if (raddr >= 8'd16 && raddr < 8'd32) begin
                rdata <= (wr_total == wr_base) ? buf0[raddr - 8'd16]
                                               : buf1[raddr - 8'd16];
            end else begin
                rdata <= 8'hEE;
            end
        end
        if (we) begin
            wa_log[wr_total % 256] <= waddr;
            wd_log[wr_total % 256] <= wdata;
            wr_total <= wr_total + 1;
        end
        if (valid && ready) begin
            st_data[cap_total % 1024]  <= fdata;
            st_first[cap_total % 1024] <= first;
            st_last[cap_total % 1024]  <= last;
            cap_total <= cap_total + 1;
        end
    end

    task automatic load(input int bank);
        for (int i = 0; i < 16; i++) begin
            if (bank == 0) buf0[i] = (i < eq.size()) ? eq[i] : 8'h99;
            else           buf1[i] = (i < eq.size()) ? eq[i] : 8'h99;
        end
    endtask

    task automatic mark();
        rd_base  = rd_total;
        sr_base  = sr_total;
        wr_base  = wr_total;
        cap_base = cap_total;
    endtask

    task automatic fire(input string tag);
        int k;
        k = 0;
        irq_n = 1'b0;
        while (!re && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        irq_n = 1'b1;
        chk({tag, ".irq_ack"}, 32'(re), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 600) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!valid && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, ".valid"}, 32'(valid), 32'd1);
    endtask

    function automatic int max_rd();
        int m;
        m = 0;
        for (int i = rd_base; i < rd_total; i++)
            if (int'(rd_log[i % 1024]) > m) m = int'(rd_log[i % 1024]);
        return m;
    endfunction

    function automatic int cnt_rd(input logic [7:0] a);
        int c;
        c = 0;
        for (int i = rd_base; i < rd_total; i++)
            if (rd_log[i % 1024] == a) c++;
        return c;
    endfunction

    task automatic check_stream(input string tag, input logic [15:0] fm,
                                input logic [15:0] lm);
        int n;
        logic [15:0] gf, gl;
        n  = cap_total - cap_base;
        gf = '0;
        gl = '0;
        chk({tag, ".len"}, n, eq.size());
        for (int i = 0; i < eq.size() && i < n; i++)
            chk($sformatf("%s.b%0d", tag, i),
                32'(st_data[(cap_base + i) % 1024]), 32'(eq[i]));
        for (int i = 0; i < n && i < 16; i++) begin
            gf[i] = st_first[(cap_base + i) % 1024];
            gl[i] = st_last[(cap_base + i) % 1024];
        end
        chk({tag, ".first"}, 32'(gf), 32'(fm));
        chk({tag, ".last"}, 32'(gl), 32'(lm));
    endtask

    task automatic check_rrb(input string tag, input int n);
        chk({tag, ".nwr"}, wr_total - wr_base, n);
        for (int i = 0; i < n; i++) begin
            chk({tag, ".waddr"}, 32'(wa_log[(wr_base + i) % 256]), 32'd1);
            chk({tag, ".wdata"}, 32'(wd_log[(wr_base + i) % 256]), 32'h04);
        end
    endtask

    initial begin
        int t_re, t_v, rc;
        logic [7:0] sd;
        logic sf, sl, stable;

        for (int i = 0; i < 4; i++) sr_seq[i] = 8'h00;
        eq = {};
        load(0);
        load(1);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", 32'(busy), 0);
        chk("rst.valid", 32'(valid), 0);
        chk("rst.re", 32'(re), 0);
        chk("rst.we", 32'(we), 0);
        chk("rst.cnt", 32'(fcnt), 0);
        chk("rst.addr", {16'd0, raddr, waddr}, 0);
        res_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // SFF data frame plus minimum latency
        ir_val = 8'h01;
        eq = {8'h03, 8'hA5, 8'h40, 8'h11, 8'h22, 8'h33};
        load(0);
        mark();
        irq_n = 1'b0;
        t_re = -1;
        t_v = -1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (re && t_re < 0) t_re = k;
            if (valid && t_v < 0) t_v = k;
        end
        irq_n = 1'b1;
        chk("sff.lat_re", t_re, 1);
        chk("sff.lat_valid", t_v, 5);
        chk("sff.ir_addr", 32'(rd_log[rd_base % 1024]), 3);
        wait_idle("sff");
        check_stream("sff", 16'h0001, 16'h0020);
        check_rrb("sff", 1);
        chk("sff.cnt", 32'(fcnt), 1);

        // EFF remote frame: 5 bytes, no data reads
        eq = {8'hC4, 8'h11, 8'h22, 8'h33, 8'h44};
        load(0);
        mark();
        fire("eff");
        wait_idle("eff");
        check_stream("eff", 16'h0001, 16'h0010);
        chk("eff.maxaddr", max_rd(), 20);
        chk("eff.cnt", 32'(fcnt), 2);

        // FD DLC 0xF clamps to 8 data bytes
        eq = {8'h0F, 8'h12, 8'h34, 8'h01, 8'h02, 8'h03, 8'h04,
              8'h05, 8'h06, 8'h07, 8'h08};
        load(0);
        mark();
        fire("fd");
        wait_idle("fd");
        check_stream("fd", 16'h0001, 16'h0400);
        chk("fd.maxaddr", max_rd(), 26);
        chk("fd.info_rd", cnt_rd(8'd16), 1);
        chk("fd.cnt", 32'(fcnt), 3);

        // backpressure mid-frame
        eq = {8'h08, 8'hAB, 8'hCD, 8'hD0, 8'hD1, 8'hD2, 8'hD3,
              8'hD4, 8'hD5, 8'hD6, 8'hD7};
        load(0);
        mark();
        fire("bp");
        rc = 0;
        while (cap_total - cap_base < 3 && rc < 100) begin
            @(posedge clk); #1;
            rc++;
        end
        ready = 1'b0;
        wait_valid("bp");
        sd = fdata;
        sf = first;
        sl = last;
        rc = rd_total;
        stable = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (!valid || fdata != sd || first != sf || last != sl)
                stable = 1'b0;
        end
        chk("bp.stable", 32'(stable), 1);
        chk("bp.noread", rd_total - rc, 0);
        ready = 1'b1;
        wait_idle("bp");
        check_stream("bp", 16'h0001, 16'h0400);
        chk("bp.cnt", 32'(fcnt), 4);

        // back-to-back frames via SR.RBS
        eq = {8'h00, 8'h77, 8'h88};
        load(1);
        eq = {8'h01, 8'h12, 8'h34, 8'h55};
        load(0);
        sr_seq[0] = 8'h01;
        sr_seq[1] = 8'h00;
        mark();
        fire("b2b");
        wait_idle("b2b");
        eq = {8'h01, 8'h12, 8'h34, 8'h55, 8'h00, 8'h77, 8'h88};
        check_stream("b2b", 16'h0011, 16'h0048);
        check_rrb("b2b", 2);
        chk("b2b.ir_rd", cnt_rd(8'd3), 1);
        chk("b2b.cnt", 32'(fcnt), 6);
        sr_seq[0] = 8'h00;

        // IR without RI
        ir_val = 8'h04;
        mark();
        fire("nri");
        wait_idle("nri");
        repeat (5) @(posedge clk);
        #1;
        chk("nri.reads", rd_total - rd_base, 1);
        chk("nri.writes", wr_total - wr_base, 0);
        chk("nri.stream", cap_total - cap_base, 0);
        chk("nri.cnt", 32'(fcnt), 6);

        // reset during EMIT
        ir_val = 8'h01;
        eq = {8'h03, 8'hA5, 8'h40, 8'h11, 8'h22, 8'h33};
        load(0);
        mark();
        ready = 1'b0;
        fire("mrst");
        wait_valid("mrst");
        repeat (2) @(posedge clk);
        #1;
        res_n = 1'b0;
        #1;
        chk("mrst.valid", 32'(valid), 0);
        chk("mrst.busy", 32'(busy), 0);
        chk("mrst.cnt", 32'(fcnt), 0);
        chk("mrst.flags", {29'd0, first, last, re}, 0);
        @(posedge clk); #1;
        res_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mrst.nowr", wr_total - wr_base, 0);
        chk("mrst.nocap", cap_total - cap_base, 0);
        ready = 1'b1;
        mark();
        fire("rest");
        wait_idle("rest");
        check_stream("rest", 16'h0001, 16'h0020);
        check_rrb("rest", 1);
        chk("rest.cnt", 32'(fcnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
